// File: rtl/fifo_flex.sv
// Parametrised single-clock FIFO: any DEPTH >= 2, occupancy count, threshold and sticky error flags.
// Define FIFO_FLEX_FWFT_EN for first-word-fall-through reads; default is registered reads.
module fifo_flex #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 1,
    parameter int unsigned AE_THRESH  = 1,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_en_c, rd_en_c;

    // Non-power-of-two wrap: DEPTH-1 rolls over to 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_WIDTH'(DEPTH));
    assign almost_empty = (count_q <= CNT_WIDTH'(AE_THRESH));
    assign almost_full  = (count_q >= CNT_WIDTH'(AF_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_en_c = wr && !full && !clear;
    assign rd_en_c = rd && !empty && !clear;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en_c) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en_c) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_en_c && !rd_en_c) count_d = count_q + CNT_WIDTH'(1);
            if (rd_en_c && !wr_en_c) count_d = count_q - CNT_WIDTH'(1);
            if (wr && full)  overflow_d  = 1'b1;
            if (rd && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset or cleared.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef FIFO_FLEX_FWFT_EN
    assign data_out       = mem_q[rd_ptr_q];
    assign data_out_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_out_valid_q, data_out_valid_d;

    always_comb begin
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        if (clear) begin
            data_out_d = '0;
        end else if (rd_en_c) begin
            data_out_d       = mem_q[rd_ptr_q];
            data_out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
`endif

endmodule
